// File: rtl/qam16_pkg.sv
// qam16_pkg: constants and FSM encoding shared by the QAM16 packer and unpacker.
package qam16_pkg;

    localparam int QAM16_SYM_W   = 4;
    localparam int QAM16_DIBIT_W = 2;
    localparam int QAM16_RATIO   = QAM16_SYM_W / QAM16_DIBIT_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } qam16_state_e;

endpackage

// File: rtl/qam16_sync_fifo.sv
// qam16_sync_fifo: single-clock FIFO with occupancy count; flush beats push and pop.
module qam16_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             wr_en, rd_en;

    // Full blocks writes even when a read happens in the same cycle.
    assign wr_en = push && !flush && (level_q != LW'(DEPTH));
    assign rd_en = pop && !flush && (level_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_en && !rd_en) level_q <= level_q + LW'(1);
            else if (!wr_en && rd_en) level_q <= level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/qam16_sym_unpacker.sv
// qam16_sym_unpacker: buffers demapped QAM16 symbol words and re-serialises them
// into dibits with valid/ready on both sides.
module qam16_sym_unpacker
    import qam16_pkg::*;
#(
    parameter int SYM_W      = QAM16_SYM_W,
    parameter int OUT_W      = QAM16_DIBIT_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [SYM_W-1:0]                din,
    input  logic                            din_valid,
    output logic                            din_ready,
    output logic [OUT_W-1:0]                dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int RATIO = SYM_W / OUT_W;
    localparam int LNW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int LW    = $clog2(FIFO_DEPTH + 1);

    qam16_state_e     state_q, state_d;
    logic [SYM_W-1:0] sh_q, sh_d;
    logic [LNW-1:0]   lane_q, lane_d;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic [SYM_W-1:0] fifo_rdata;
    logic             push, pop, emit, last_lane, fifo_empty;

    function automatic logic [OUT_W-1:0] lane_sel(input logic [SYM_W-1:0] w, input logic [LNW-1:0] l);
        logic [SYM_W-1:0] msb_s;
        logic [SYM_W-1:0] lsb_s;
        msb_s = w << (l * OUT_W);
        lsb_s = w >> (l * OUT_W);
        return (MSB_FIRST != 0) ? msb_s[SYM_W-1 -: OUT_W] : lsb_s[OUT_W-1:0];
    endfunction

    assign din_ready  = rst_n && (fifo_level != LW'(FIFO_DEPTH));
    assign push       = din_valid && din_ready;
    assign fifo_empty = (fifo_level == '0);
    assign emit       = dout_valid_q && dout_ready;
    assign last_lane  = (lane_q == LNW'(RATIO - 1));
    // Reload straight from the FIFO on the last lane so streaming has no bubble.
    assign pop        = !flush && !fifo_empty && ((state_q == ST_IDLE) || (emit && last_lane));

    qam16_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SYM_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata (din),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (fifo_level)
    );

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        lane_d       = lane_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (flush) begin
            state_d      = ST_IDLE;
            lane_d       = '0;
            dout_d       = '0;
            dout_valid_d = 1'b0;
        end else if (pop) begin
            state_d      = ST_SHIFT;
            sh_d         = fifo_rdata;
            lane_d       = '0;
            dout_d       = lane_sel(fifo_rdata, '0);
            dout_valid_d = 1'b1;
        end else if (emit && last_lane) begin
            state_d      = ST_IDLE;
            dout_valid_d = 1'b0;
        end else if (emit) begin
            lane_d = lane_q + LNW'(1);
            dout_d = lane_sel(sh_q, lane_q + LNW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sh_q         <= '0;
            lane_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            lane_q       <= lane_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_qam16_sym_unpacker.sv
// tb_qam16_sym_unpacker: directed checks of the symbol unpacker, MSB-first and LSB-first.
module tb_qam16_sym_unpacker;

    logic       clk, rst_n, flush, din_valid, dout_ready;
    logic [3:0] din;
    logic       din_ready, dout_valid, din_ready_l, dout_valid_l;
    logic [1:0] dout, dout_l;
    logic [2:0] fifo_level, fifo_level_l;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    logic [1:0] got [$];
    logic [1:0] exp_q [$];

    qam16_sym_unpacker #(.MSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .fifo_level(fifo_level)
    );

    qam16_sym_unpacker #(.MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_l), .dout(dout_l), .dout_valid(dout_valid_l),
        .dout_ready(dout_ready), .fifo_level(fifo_level_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_word(input logic [3:0] w);
        exp_q.push_back(w[3:2]);
        exp_q.push_back(w[1:0]);
    endtask

    task automatic collect(input int n, input int budget);
        for (int c = 0; c < budget && got.size() < n; c++) begin
            if (dout_valid && dout_ready) got.push_back(dout);
            tick();
        end
        chk("collect_count", got.size(), n);
    endtask

    task automatic cmp_stream(input string tag);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, got[i], exp_q[i]);
    endtask

    initial begin
        int wi, gaps, bad_rdy, idx;
        logic acc, started;
        logic [3:0] bp_w [5];
        rst_n = 1'b0; flush = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
        #2;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_dout", dout, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_din_ready", din_ready, 1);

        // single word, MSB first on dut and LSB first on dut_lsb
        dout_ready = 1'b1; din = 4'b1011; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("single_not_yet_valid", dout_valid, 0);
        chk("single_level_1", fifo_level, 1);
        tick();
        chk("single_valid0", dout_valid, 1);
        chk("single_dibit0", dout, 2'b10);
        chk("single_lsb_dibit0", dout_l, 2'b11);
        chk("single_level_0", fifo_level, 0);
        tick();
        chk("single_valid1", dout_valid, 1);
        chk("single_dibit1", dout, 2'b11);
        chk("single_lsb_dibit1", dout_l, 2'b10);
        tick();
        chk("single_done", dout_valid, 0);
        chk("single_lsb_done", dout_valid_l, 0);

        // streaming 0x1..0xF with the sink always ready
        got.delete(); exp_q.delete();
        for (int w = 1; w < 16; w++) add_word(4'(w));
        wi = 1; din = 4'h1; din_valid = 1'b1; gaps = 0; bad_rdy = 0; started = 1'b0;
        for (int c = 0; c < 100 && got.size() < 30; c++) begin
            acc = din_valid && din_ready;
            if (dout_valid) begin
                got.push_back(dout);
                started = 1'b1;
            end else if (started) gaps++;
            if (din_ready !== (fifo_level != 3'd4)) bad_rdy++;
            tick();
            if (acc) begin
                if (wi == 15) din_valid = 1'b0;
                else begin
                    wi++;
                    din = 4'(wi);
                end
            end
        end
        chk("stream_count", got.size(), 30);
        chk("stream_gaps", gaps, 0);
        chk("stream_din_ready", bad_rdy, 0);
        cmp_stream("stream_dibit");
        for (int c = 0; c < 10 && dout_valid; c++) tick();
        chk("stream_idle", dout_valid, 0);

        // backpressure: five words go in with the sink stalled
        dout_ready = 1'b0;
        bp_w[0] = 4'hD; bp_w[1] = 4'h5; bp_w[2] = 4'h9; bp_w[3] = 4'hA; bp_w[4] = 4'hE;
        idx = 0; din = bp_w[0]; din_valid = 1'b1;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            acc = din_valid && din_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 5) din = bp_w[idx];
            end
        end
        chk("bp_accepted", idx, 5);
        din = 4'h7;
        chk("bp_din_ready", din_ready, 0);
        chk("bp_level", fifo_level, 4);
        chk("bp_valid", dout_valid, 1);
        chk("bp_dout", dout, 2'b11);
        tick();
        tick();
        chk("bp_dout_stable", dout, 2'b11);
        chk("bp_level_stable", fifo_level, 4);
        chk("bp_din_ready_held", din_ready, 0);

        // release with 0x7 still offered: last-lane pop on a full FIFO must not write
        got.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) add_word(bp_w[i]);
        add_word(4'h7);
        dout_ready = 1'b1;
        got.push_back(dout);
        tick();
        chk("full_lane1_dout", dout, 2'b01);
        chk("full_lane1_level", fifo_level, 4);
        got.push_back(dout);
        tick();
        chk("full_pop_no_write", fifo_level, 3);
        chk("full_din_ready_back", din_ready, 1);
        got.push_back(dout);
        tick();
        din_valid = 1'b0;
        chk("full_deferred_write", fifo_level, 4);
        collect(12, 40);
        cmp_stream("bp_dibit");
        for (int c = 0; c < 10 && dout_valid; c++) tick();
        chk("bp_idle", dout_valid, 0);

        // flush after the first dibit of 0xC; 0x9 offered during flush is dropped
        din = 4'hC; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        chk("flush_first_dibit", dout, 2'b11);
        tick();
        chk("flush_second_dibit", dout, 2'b00);
        flush = 1'b1; din = 4'h9; din_valid = 1'b1;
        tick();
        flush = 1'b0; din = 4'h6;
        chk("flush_valid", dout_valid, 0);
        chk("flush_level", fifo_level, 0);
        chk("flush_dout", dout, 0);
        tick();
        din_valid = 1'b0;
        chk("flush_6_latency", dout_valid, 0);
        got.delete(); exp_q.delete();
        add_word(4'h6);
        collect(2, 10);
        cmp_stream("flush_6_dibit");
        tick();
        tick();
        chk("flush_no_extra", dout_valid, 0);
        chk("flush_no_extra_level", fifo_level, 0);

        // reset mid-symbol
        din = 4'hF; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        chk("midrst_pre_valid", dout_valid, 1);
        din = 4'h3; din_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_din_ready", din_ready, 0);
        chk("midrst_dout", dout, 0);
        din_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_release_ready", din_ready, 1);
        tick();
        tick();
        chk("midrst_no_emit", dout_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
